// File: rtl/crc_engine_if.sv
// Byte/bit handshake bundle between a CRC data source and crc_engine.
// WIDTH must match the engine instance it is bound to.
interface crc_engine_if #(
    parameter int WIDTH = 16
);
    logic             clear;
    logic [7:0]       din;
    logic             din_valid;
    logic             ready;
    logic             bit_in;
    logic             bit_valid;
    logic             byte_done;
    logic [WIDTH-1:0] crc_out;
    logic             residue_ok;

    modport master (
        output clear, din, din_valid, bit_in, bit_valid,
        input  ready, byte_done, crc_out, residue_ok
    );

    modport slave (
        input  clear, din, din_valid, bit_in, bit_valid,
        output ready, byte_done, crc_out, residue_ok
    );
endinterface

// File: rtl/crc_engine.sv
// Parametrised bit-serial CRC generator/checker. Bytes are serialised MSB
// first over 8 falling edges; single bits fold in on the accepting edge.
module crc_engine #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] POLY    = WIDTH'(16'h1021),
    parameter logic [WIDTH-1:0] INIT    = '0,
    parameter logic [WIDTH-1:0] XOR_OUT = '0,
    parameter logic [WIDTH-1:0] RESIDUE = '0
) (
    input  logic       spi_clk_i,
    input  logic       reset_i,
    crc_engine_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] crc_q, crc_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             byte_done_q, byte_done_d;

    // One division step; the implicit x^WIDTH term is the feedback bit.
    function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] c,
                                                  input logic b);
        logic fb;
        fb = b ^ c[WIDTH-1];
        return (c << 1) ^ (fb ? POLY : '0);
    endfunction

    always_ff @(negedge spi_clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = 1'b0;
        if (bus.clear) begin
            // Abort: any byte in flight is dropped without a byte_done.
            state_d = IDLE;
            crc_d   = INIT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.din_valid) begin
                        shreg_d   = bus.din;
                        bit_cnt_d = 3'd7;
                        state_d   = SHIFT;
                    end else if (bus.bit_valid) begin
                        crc_d = crc_step(crc_q, bus.bit_in);
                    end
                end
                SHIFT: begin
                    crc_d     = crc_step(crc_q, shreg_q[7]);
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        byte_done_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ready      = (state_q == IDLE);
        bus.byte_done  = byte_done_q;
        bus.crc_out    = crc_q ^ XOR_OUT;
        bus.residue_ok = (crc_q == RESIDUE);
    end

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench: four engine flavours share one stimulus stream and each
// output is compared against hand-computed CRC values.
module tb_crc_engine;

    logic       spi_clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [7:0] din;
    logic       din_valid;
    logic       bit_in;
    logic       bit_valid;

    always #5 spi_clk = ~spi_clk;

    crc_engine_if #(.WIDTH(16)) if16a ();
    crc_engine_if #(.WIDTH(16)) if16b ();
    crc_engine_if #(.WIDTH(8))  if8 ();
    crc_engine_if #(.WIDTH(7))  if7 ();

    assign if16a.clear = clear;  assign if16a.din = din;  assign if16a.din_valid = din_valid;
    assign if16a.bit_in = bit_in; assign if16a.bit_valid = bit_valid;
    assign if16b.clear = clear;  assign if16b.din = din;  assign if16b.din_valid = din_valid;
    assign if16b.bit_in = bit_in; assign if16b.bit_valid = bit_valid;
    assign if8.clear = clear;    assign if8.din = din;    assign if8.din_valid = din_valid;
    assign if8.bit_in = bit_in;   assign if8.bit_valid = bit_valid;
    assign if7.clear = clear;    assign if7.din = din;    assign if7.din_valid = din_valid;
    assign if7.bit_in = bit_in;   assign if7.bit_valid = bit_valid;

    crc_engine #(.WIDTH(16), .POLY(16'h1021), .INIT(16'h0000), .XOR_OUT(16'h0000), .RESIDUE(16'h0000))
        u16a (.spi_clk_i(spi_clk), .reset_i(reset), .bus(if16a));
    crc_engine #(.WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000), .RESIDUE(16'h0000))
        u16b (.spi_clk_i(spi_clk), .reset_i(reset), .bus(if16b));
    crc_engine #(.WIDTH(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .RESIDUE(8'h00))
        u8 (.spi_clk_i(spi_clk), .reset_i(reset), .bus(if8));
    crc_engine #(.WIDTH(7), .POLY(7'h09), .INIT(7'h00), .XOR_OUT(7'h00), .RESIDUE(7'h00))
        u7 (.spi_clk_i(spi_clk), .reset_i(reset), .bus(if7));

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int bd_total = 0;
    int bd_time [128];

    always @(posedge spi_clk) begin
        cyc <= cyc + 1;
        if (if16a.byte_done) begin
            if (bd_total < 128) bd_time[bd_total] <= cyc;
            bd_total <= bd_total + 1;
        end
    end

    typedef struct {
        logic [7:0]  din;
        logic [15:0] e16;
        logic [15:0] e16f;
        logic [7:0]  e8;
        logic [6:0]  e7;
    } vec_t;

    vec_t vt [4];

    task automatic tick();
        @(posedge spi_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!if16a.ready && n < 40) begin
            tick();
            n++;
        end
        if (!if16a.ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (8) tick();
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bit_in    = b[i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_check_str();
        for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i));
    endtask

    initial begin
        int s0;
        logic [7:0] cmd [5];

        vt[0] = '{din: 8'h00, e16: 16'h0000, e16f: 16'hE1F0, e8: 8'h00, e7: 7'h00};
        vt[1] = '{din: 8'h01, e16: 16'h1021, e16f: 16'hF1D1, e8: 8'h07, e7: 7'h09};
        vt[2] = '{din: 8'h80, e16: 16'h9188, e16f: 16'h7078, e8: 8'h89, e7: 7'h41};
        vt[3] = '{din: 8'hFF, e16: 16'h1EF0, e16f: 16'hFF00, e8: 8'hF3, e7: 7'h79};
        cmd = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};

        reset = 1'b1; clear = 1'b0; din = '0; din_valid = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        repeat (3) tick();
        check("rst_ready", 32'(if16a.ready), 32'd1);
        check("rst_bd", 32'(if16a.byte_done), 32'd0);
        check("rst_crc16a", 32'(if16a.crc_out), 32'h0000);
        check("rst_crc16b", 32'(if16b.crc_out), 32'hFFFF);
        check("rst_res16a", 32'(if16a.residue_ok), 32'd1);
        check("rst_res16b", 32'(if16b.residue_ok), 32'd0);
        reset = 1'b0;
        tick();

        // Single-byte table
        for (int v = 0; v < 4; v++) begin
            do_clear();
            s0 = bd_total;
            send_byte(vt[v].din);
            check($sformatf("vec%0d_c16", v), 32'(if16a.crc_out), 32'(vt[v].e16));
            check($sformatf("vec%0d_c16f", v), 32'(if16b.crc_out), 32'(vt[v].e16f));
            check($sformatf("vec%0d_c8", v), 32'(if8.crc_out), 32'(vt[v].e8));
            check($sformatf("vec%0d_c7", v), 32'(if7.crc_out), 32'(vt[v].e7));
            check($sformatf("vec%0d_bd", v), 32'(bd_total - s0), 32'd1);
        end

        // "123456789" byte stream, back to back
        do_clear();
        s0 = bd_total;
        send_check_str();
        check("str_c16", 32'(if16a.crc_out), 32'h31C3);
        check("str_c16f", 32'(if16b.crc_out), 32'h29B1);
        check("str_c8", 32'(if8.crc_out), 32'hF4);
        check("str_c7", 32'(if7.crc_out), 32'h75);
        check("str_ready", 32'(if16a.ready), 32'd1);
        check("str_bdcnt", 32'(bd_total - s0), 32'd9);
        for (int k = 0; k < 8; k++)
            check($sformatf("str_gap%0d", k), 32'(bd_time[s0+k+1] - bd_time[s0+k]), 32'd9);

        send_byte(8'h31);
        send_byte(8'hC3);
        check("res_crc", 32'(if16a.crc_out), 32'h0000);
        check("res_ok", 32'(if16a.residue_ok), 32'd1);

        do_clear();
        send_check_str();
        send_byte(8'h31);
        send_byte(8'hC2);
        check("res_bad", 32'(if16a.residue_ok), 32'd0);

        // Same string as 72 serial bits
        do_clear();
        s0 = bd_total;
        for (int i = 0; i < 9; i++) send_bits(8'h31 + 8'(i));
        check("bits_c8", 32'(if8.crc_out), 32'hF4);
        check("bits_c16", 32'(if16a.crc_out), 32'h31C3);
        check("bits_bd", 32'(bd_total - s0), 32'd0);

        // SD CMD0 CRC7
        do_clear();
        for (int i = 0; i < 5; i++) send_byte(cmd[i]);
        check("cmd0_c7", 32'(if7.crc_out), 32'h4A);

        // Clear on the 4th SHIFT edge
        do_clear();
        s0 = bd_total;
        din = 8'hFF; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_c16", 32'(if16a.crc_out), 32'h0000);
        check("clr_c16f", 32'(if16b.crc_out), 32'hFFFF);
        check("clr_ready", 32'(if16a.ready), 32'd1);
        repeat (10) tick();
        check("clr_nobd", 32'(bd_total - s0), 32'd0);

        // Byte and bit together: only the byte counts
        din = 8'h80; din_valid = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        tick();
        din_valid = 1'b0; bit_valid = 1'b0;
        repeat (8) tick();
        check("both_c16", 32'(if16a.crc_out), 32'h9188);
        check("both_c8", 32'(if8.crc_out), 32'h89);

        // Reset mid-SHIFT
        s0 = bd_total;
        din = 8'h5A; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_ready", 32'(if16a.ready), 32'd1);
        check("mrst_bd", 32'(if16a.byte_done), 32'd0);
        check("mrst_c16f", 32'(if16b.crc_out), 32'hFFFF);
        check("mrst_c8", 32'(if8.crc_out), 32'h00);
        repeat (10) tick();
        check("mrst_nobd", 32'(bd_total - s0), 32'd0);

        // din_valid pulsed while busy must be ignored
        do_clear();
        din = 8'h31; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (3) tick();
        din = 8'hAA; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (4) tick();
        for (int i = 1; i < 9; i++) send_byte(8'h31 + 8'(i));
        check("busy_c16", 32'(if16a.crc_out), 32'h31C3);
        check("busy_c7", 32'(if7.crc_out), 32'h75);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
